// File: rtl/imm_gen_stage_pkg.sv
// Shared types and constants for the immediate-generation stage.
// Holds format codes, RV32I/RV64I major opcodes and the funct3 values that select shift-immediate decoding.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6,
      FMT_Z    = 3'd7
   } fmt_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   // SLLI/SRLI/SRAI carry a shift amount instead of a 12-bit signed immediate.
   function automatic logic isShiftFunct3(input logic [2:0] funct3);
      return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
   endfunction

   function automatic logic isCsrImmFunct3(input logic [2:0] funct3);
      return funct3[2];
   endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream and downstream valid/ready channels of the immediate-generation stage.
// The stage uses the slave modport; whatever feeds and drains it uses master.
interface imm_gen_stage_if
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) ();

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   fmt_t            out_fmt;
   logic            out_illegal;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_pc;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target, out_pc
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target, out_pc
   );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: instruction word and PC in, immediate, format,
// illegal flag and PC-relative target out.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_t            fmt_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] target_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm32;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];

   // Every format fits in 32 bits already sign-extended; zero-extended fields keep bit 31 clear.
   always_comb begin
      imm32     = '0;
      fmt_o     = FMT_NONE;
      illegal_o = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            fmt_o = FMT_U;
            imm32 = {inst_i[31:12], 12'b0};
         end
         OPC_JAL: begin
            fmt_o = FMT_J;
            imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         end
         OPC_BRANCH: begin
            fmt_o = FMT_B;
            imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         end
         OPC_STORE: begin
            fmt_o = FMT_S;
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         OPC_JALR, OPC_LOAD: begin
            fmt_o = FMT_I;
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OPC_OP_IMM: begin
            if (isShiftFunct3(funct3)) begin
               fmt_o = FMT_SH;
               if (XLEN == 64) begin
                  imm32 = {26'b0, inst_i[25:20]};
               end else begin
                  imm32 = {27'b0, inst_i[24:20]};
               end
            end else begin
               fmt_o = FMT_I;
               imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
         end
         OPC_SYSTEM: begin
            if (isCsrImmFunct3(funct3)) begin
               fmt_o = FMT_Z;
               imm32 = {27'b0, inst_i[19:15]};
            end else begin
               fmt_o = FMT_I;
               imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

   assign imm_o    = XLEN'($signed(imm32));
   assign target_o = pc_i + imm_o;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode at the input, then an output register
// backed by a single skid entry so upstream ready never depends on downstream ready.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   imm_gen_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      fmt_t            fmt;
      logic            illegal;
   } entry_t;

   logic [XLEN-1:0] decImm;
   logic [XLEN-1:0] decTarget;
   fmt_t            decFmt;
   logic            decIllegal;
   entry_t          decEntry;

   entry_t outEntry_q;
   entry_t outEntry_d;
   entry_t skidEntry_q;
   entry_t skidEntry_d;
   logic   outValid_q;
   logic   outValid_d;
   logic   skidValid_q;
   logic   skidValid_d;

   logic accept;
   logic outFire;
   logic outLoad;

   imm_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .inst_i   (bus.in_inst),
      .pc_i     (bus.in_pc),
      .imm_o    (decImm),
      .fmt_o    (decFmt),
      .illegal_o(decIllegal),
      .target_o (decTarget)
   );

   assign decEntry = '{imm: decImm, target: decTarget, pc: bus.in_pc, fmt: decFmt, illegal: decIllegal};

   assign accept  = bus.in_valid & ~skidValid_q;
   assign outFire = outValid_q & bus.out_ready;
   assign outLoad = ~outValid_q | outFire;

   // The skid entry is older than any new input, so it always wins the output register;
   // upstream is already blocked while it is valid, so the two never compete.
   always_comb begin
      outEntry_d  = outEntry_q;
      skidEntry_d = skidEntry_q;
      outValid_d  = outValid_q;
      skidValid_d = skidValid_q;
      if (flush) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end else if (outLoad) begin
         if (skidValid_q) begin
            outEntry_d  = skidEntry_q;
            outValid_d  = 1'b1;
            skidValid_d = 1'b0;
         end else begin
            outValid_d = accept;
            if (accept) begin
               outEntry_d = decEntry;
            end
         end
      end else if (accept) begin
         skidEntry_d = decEntry;
         skidValid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outEntry_q  <= '0;
         skidEntry_q <= '0;
         outValid_q  <= 1'b0;
         skidValid_q <= 1'b0;
      end else begin
         outEntry_q  <= outEntry_d;
         skidEntry_q <= skidEntry_d;
         outValid_q  <= outValid_d;
         skidValid_q <= skidValid_d;
      end
   end

   assign bus.in_ready    = ~skidValid_q;
   assign bus.out_valid   = outValid_q;
   assign bus.out_imm     = outEntry_q.imm;
   assign bus.out_fmt     = outEntry_q.fmt;
   assign bus.out_illegal = outEntry_q.illegal;
   assign bus.out_target  = outEntry_q.target;
   assign bus.out_pc      = outEntry_q.pc;

endmodule
